// File: rtl/input_debouncer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | input_debouncer: synchronizes, debounces and edge-detects one raw input.  |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module input_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       d_raw,
    input  logic       en,
    output logic       d_clean,
    output logic       rise,
    output logic       fall,
    output logic [7:0] glitch_cnt
);

    localparam logic [1:0] IDLE_LO  = 2'd0;
    localparam logic [1:0] CHECK_HI = 2'd1;
    localparam logic [1:0] IDLE_HI  = 2'd2;
    localparam logic [1:0] CHECK_LO = 2'd3;

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [1:0]             state;
    logic [1:0]             state_nx;
    logic [7:0]             cnt;
    logic [7:0]             cnt_nx;
    logic                   clean_nx;
    logic                   rise_nx;
    logic                   fall_nx;
    logic                   glitch_inc;

    assign s = sync[SYNC_STAGES-1];

    // The synchronizer runs regardless of en so s is always current on resume.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], d_raw};
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        clean_nx   = d_clean;
        rise_nx    = 1'b0;
        fall_nx    = 1'b0;
        glitch_inc = 1'b0;
        if (en) begin
            case (state)
                IDLE_LO: begin
                    if (s) begin
                        state_nx = CHECK_HI;
                        cnt_nx   = 8'd1;
                    end
                end
                CHECK_HI: begin
                    if (s) begin
                        if (cnt == CNT_LAST) begin
                            state_nx = IDLE_HI;
                            clean_nx = 1'b1;
                            rise_nx  = 1'b1;
                            cnt_nx   = 8'd0;
                        end else begin
                            cnt_nx = cnt + 8'd1;
                        end
                    end else begin
                        state_nx   = IDLE_LO;
                        cnt_nx     = 8'd0;
                        glitch_inc = 1'b1;
                    end
                end
                IDLE_HI: begin
                    if (!s) begin
                        state_nx = CHECK_LO;
                        cnt_nx   = 8'd1;
                    end
                end
                CHECK_LO: begin
                    if (!s) begin
                        if (cnt == CNT_LAST) begin
                            state_nx = IDLE_LO;
                            clean_nx = 1'b0;
                            fall_nx  = 1'b1;
                            cnt_nx   = 8'd0;
                        end else begin
                            cnt_nx = cnt + 8'd1;
                        end
                    end else begin
                        state_nx   = IDLE_HI;
                        cnt_nx     = 8'd0;
                        glitch_inc = 1'b1;
                    end
                end
                default: begin
                    state_nx = IDLE_LO;
                    cnt_nx   = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE_LO;
            cnt        <= 8'd0;
            d_clean    <= 1'b0;
            rise       <= 1'b0;
            fall       <= 1'b0;
            glitch_cnt <= 8'd0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            d_clean <= clean_nx;
            rise    <= rise_nx;
            fall    <= fall_nx;
            if (glitch_inc && (glitch_cnt != 8'hFF)) begin
                glitch_cnt <= glitch_cnt + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_input_debouncer.sv
`timescale 1ns/100ps
`default_nettype none
// Directed bench for input_debouncer with a run-length reference model.
module tb_input_debouncer;

    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 4;

    logic       clk;
    logic       reset;
    logic       d_raw;
    logic       en;
    logic       d_clean;
    logic       rise;
    logic       fall;
    logic [7:0] glitch_cnt;

    int n_vec;
    int n_bad;

    input_debouncer #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .d_raw     (d_raw),
        .en        (en),
        .d_clean   (d_clean),
        .rise      (rise),
        .fall      (fall),
        .glitch_cnt(glitch_cnt)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Model: history of d_raw samples; the debouncer sees the sample taken
    // SYNC_STAGES edges ago and counts how long it has disagreed with the level.
    logic [31:0] m_hist;
    logic        m_clean;
    logic        m_rise;
    logic        m_fall;
    int          m_run;
    logic [7:0]  m_glitch;
    logic        m_s;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hist   <= '0;
            m_clean  <= 1'b0;
            m_rise   <= 1'b0;
            m_fall   <= 1'b0;
            m_run    <= 0;
            m_glitch <= 8'd0;
        end else begin
            m_hist <= {m_hist[30:0], d_raw};
            m_rise <= 1'b0;
            m_fall <= 1'b0;
            if (en) begin
                m_s = m_hist[SYNC_STAGES-1];
                if (m_s != m_clean) begin
                    if (m_run + 1 == DEBOUNCE_CYCLES) begin
                        m_clean <= m_s;
                        m_rise  <= m_s;
                        m_fall  <= ~m_s;
                        m_run   <= 0;
                    end else begin
                        m_run <= m_run + 1;
                    end
                end else if (m_run != 0) begin
                    m_run <= 0;
                    if (m_glitch != 8'd255) m_glitch <= m_glitch + 8'd1;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model d_clean", int'(d_clean), int'(m_clean));
        chk("model rise", int'(rise), int'(m_rise));
        chk("model fall", int'(fall), int'(m_fall));
        chk("model glitch_cnt", int'(glitch_cnt), int'(m_glitch));
        chk("rise&fall exclusive", int'(rise & fall), 0);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset = 1'b0;
        d_raw = 1'b0;
        en    = 1'b1;
        tick(3);
        chk("reset d_clean", int'(d_clean), 0);
        chk("reset glitch_cnt", int'(glitch_cnt), 0);
        reset = 1'b1;

        // Step input high right after release: level follows at edge 6.
        d_raw = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick(1);
            chk("latency d_clean low", int'(d_clean), 0);
        end
        tick(1);
        chk("edge6 d_clean", int'(d_clean), 1);
        chk("edge6 rise", int'(rise), 1);
        tick(1);
        chk("edge7 rise", int'(rise), 0);

        d_raw = 1'b0;
        tick(10);
        chk("back low d_clean", int'(d_clean), 0);

        // Three-cycle pulse is rejected once.
        d_raw = 1'b1;
        tick(3);
        d_raw = 1'b0;
        tick(8);
        chk("short pulse d_clean", int'(d_clean), 0);
        chk("short pulse glitch", int'(glitch_cnt), 1);

        // Four-cycle pulse is the shortest accepted one.
        d_raw = 1'b1;
        tick(4);
        d_raw = 1'b0;
        tick(10);
        chk("min pulse glitch", int'(glitch_cnt), 1);
        chk("min pulse d_clean", int'(d_clean), 0);

        // Input toggling every 23 ns against a 40 ns clock.
        #0.5;
        repeat (24) begin
            d_raw = ~d_raw;
            #23;
        end
        d_raw = 1'b0;
        @(negedge clk);
        tick(12);

        // Freeze with cnt=2 in the high check, then resume.
        d_raw = 1'b1;
        tick(4);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("frozen d_clean", int'(d_clean), 0);
            chk("frozen rise", int'(rise), 0);
        end
        en = 1'b1;
        tick(1);
        chk("resume+1 d_clean", int'(d_clean), 0);
        tick(1);
        chk("resume+2 d_clean", int'(d_clean), 1);
        chk("resume+2 rise", int'(rise), 1);

        d_raw = 1'b0;
        tick(10);

        // Many single-cycle glitches saturate the counter.
        repeat (300) begin
            d_raw = 1'b1;
            tick(1);
            d_raw = 1'b0;
            tick(2);
        end
        tick(4);
        chk("saturated glitch", int'(glitch_cnt), 255);
        chk("saturated d_clean", int'(d_clean), 0);

        // Reset in the middle of a low check while the level is high.
        d_raw = 1'b1;
        tick(10);
        chk("pre-reset d_clean", int'(d_clean), 1);
        d_raw = 1'b0;
        tick(4);
        #5;
        reset = 1'b0;
        #1;
        chk("async reset d_clean", int'(d_clean), 0);
        chk("async reset fall", int'(fall), 0);
        chk("async reset rise", int'(rise), 0);
        chk("async reset glitch", int'(glitch_cnt), 0);
        d_raw = 1'b1;
        @(negedge clk);
        tick(2);
        reset = 1'b1;

        // Input already high across release.
        for (int e = 1; e <= 5; e++) begin
            tick(1);
            chk("release d_clean low", int'(d_clean), 0);
        end
        tick(1);
        chk("release edge6 d_clean", int'(d_clean), 1);
        chk("release edge6 rise", int'(rise), 1);
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/input_debouncer.md
# input_debouncer

Conditions a raw, asynchronous single-bit input into a clean, synchronous level for the level-sensitive latch stage directly downstream, which consumes `d_clean` as its `d` input. Synchronizes the input, rejects pulses shorter than a programmable number of cycles, and reports clean rising and falling edges as single-cycle strobes. Also counts rejected glitches for debug visibility.

## Interface
- `SYNC_STAGES`, 2, synchronizer flop count; legal range 2..4.
- `DEBOUNCE_CYCLES`, 4, consecutive cycles the synchronized input must differ from `d_clean` before `d_clean` follows it; legal range 2..255.
- `clk`  input  1  single clock; all state updates on its rising edge.
- `reset`  input  1  asynchronous, active-low reset; asserts immediately, releases on the next `clk` rising edge.
- `d_raw`  input  1  raw asynchronous input.
- `en`  input  1  debounce enable; when 0, the FSM and counter freeze while the synchronizer keeps running.
- `d_clean`  output  1  debounced level; feeds the downstream latch `d`.
- `rise`  output  1  one-cycle strobe when `d_clean` goes 0→1.
- `fall`  output  1  one-cycle strobe when `d_clean` goes 1→0.
- `glitch_cnt`  output  8  saturating count of aborted transitions.

## Operation
- Synchronizer: shift chain `sync[0..SYNC_STAGES-1]`; `s = sync[SYNC_STAGES-1]`.
- FSM states: IDLE_LO, CHECK_HI, IDLE_HI, CHECK_LO. Counter `cnt` is 8 bits.
- IDLE_LO: if `s`=1, go to CHECK_HI with `cnt`=1; otherwise stay.
- CHECK_HI:
  - `s`=1 and `cnt`=DEBOUNCE_CYCLES-1: go to IDLE_HI, `d_clean`←1, `rise`=1, `cnt`←0.
  - `s`=1 otherwise: `cnt`+1.
  - `s`=0: go to IDLE_LO, `cnt`←0, `glitch_cnt`+1.
- IDLE_HI and CHECK_LO mirror these with polarity swapped; CHECK_LO completion asserts `fall`.
- `en`=0: state, `cnt`, `d_clean` and `glitch_cnt` hold; `rise`/`fall` are 0. The synchronizer still shifts. When `en` returns to 1, evaluation resumes from the held state against the current `s`.
- `glitch_cnt` saturates at 255 and never wraps. It is cleared only by reset.
- `rise` and `fall` are never asserted together. Each is registered and high for exactly one cycle.

## Timing
- Reset values: `sync`=0, state=IDLE_LO, `cnt`=0, `d_clean`=0, `rise`=0, `fall`=0, `glitch_cnt`=0. These apply asynchronously on `reset` falling, mid-operation included; any in-progress check is discarded.
- Latency: let edge 1 be the first edge that captures a new `d_raw` value into `sync[0]`. `s` reflects it after edge SYNC_STAGES. `d_clean` and the strobe update at edge SYNC_STAGES+DEBOUNCE_CYCLES (6 with defaults), provided `d_raw` is held and `en`=1.
- Minimum accepted pulse width: DEBOUNCE_CYCLES cycles as seen at `s`. A pulse lasting DEBOUNCE_CYCLES-1 cycles at `s` is rejected and increments `glitch_cnt` once.
- `d_raw` high across reset release: `d_clean` rises at edge SYNC_STAGES+DEBOUNCE_CYCLES after release, with a `rise` strobe.
- Back-to-back transitions: after entering IDLE_HI, a low `s` on the very next edge starts CHECK_LO with no dead cycle.

## Test plan
- Reset with `d_raw`=0, then hold `d_raw`=1 → `d_clean`=0 through edge 5, `d_clean`=1 with `rise`=1 at edge 6, `rise`=0 at edge 7.
- 3-cycle high pulse on `d_raw` (defaults) → `d_clean` stays 0, no strobes, `glitch_cnt`=1.
- Toggle `d_raw` every 23 ns with `clk` period 40 ns → `d_clean` stays 0, no strobes, `glitch_cnt` increments per aborted check.
- Drop `en` at CHECK_HI with `cnt`=2 for 5 cycles while `d_raw`=1, then raise `en` → `d_clean` rises 2 cycles after `en`=1.
- 300 glitches → `glitch_cnt` holds at 255.
- Assert `reset` while in CHECK_LO with `d_clean`=1 → all outputs 0 immediately, with no `fall` strobe.
